// File: rtl/btb_assoc.sv
// -----------------------------------------------------------------------------
// btb_assoc : fully-associative branch target buffer with tree-PLRU replacement
//
// Lookup is purely combinational. Updates go through a two-state FSM: the
// request is latched when accepted and written one edge later.
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   lookup_pc      fetch PC to look up (tag = pc[PC_W-1:2])
//   lookup_en      qualifies the lookup for a recency (PLRU) touch
//   lookup_hit     a valid entry matches lookup_pc
//   lookup_target  target of the hitting entry, 0 on miss
//   upd_valid      update request valid
//   upd_ready      update request can be accepted
//   upd_pc         resolved branch PC
//   upd_target     resolved branch target
//   flush          invalidate all entries and PLRU state on the next edge
//
// Update FSM
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for an update request; upd_ready=1 unless flushing
//   ST_ALLOC | latched request is written to the chosen way on this edge
// -----------------------------------------------------------------------------
module btb_assoc #(
    parameter int ENTRIES = 8,
    parameter int PC_W    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] lookup_pc,
    input  logic            lookup_en,
    output logic            lookup_hit,
    output logic [PC_W-1:0] lookup_target,
    input  logic            upd_valid,
    output logic            upd_ready,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic            flush
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ALLOC = 1'b1;

    logic [0:0]         state_q;
    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-2:0] plru_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [PC_W-1:0]    tgt_q [ENTRIES];
    logic [TAG_W-1:0]   upd_tag_q;
    logic [PC_W-1:0]    upd_tgt_q;

    logic [TAG_W-1:0]   look_tag;
    logic [IDX_W-1:0]   hit_way;
    logic [IDX_W-1:0]   alloc_way;
    logic               match_found;
    logic [IDX_W-1:0]   match_way;
    logic               inv_found;
    logic [IDX_W-1:0]   inv_way;
    logic [ENTRIES-2:0] plru_next;
    logic               unused_pc_bits;

    // Tree nodes are heap-ordered: node 0 is the root, level l starts at
    // node 2^l-1, and the node covering way w at level l is the one whose
    // position equals the top l bits of w.
    function automatic logic [ENTRIES-2:0] plru_touch(
        input logic [ENTRIES-2:0] tree,
        input logic [IDX_W-1:0]   way
    );
        logic [ENTRIES-2:0] res;
        res = tree;
        for (int lvl = 0; lvl < IDX_W; lvl++) begin
            for (int pos = 0; pos < (1 << lvl); pos++) begin
                if ((int'(way) >> (IDX_W - lvl)) == pos)
                    res[(1 << lvl) - 1 + pos] = ~way[IDX_W - 1 - lvl];
            end
        end
        return res;
    endfunction

    // Walk from the root; the victim bits are filled MSB first, so the
    // already-decided upper bits select the node at the next level.
    function automatic logic [IDX_W-1:0] plru_victim(
        input logic [ENTRIES-2:0] tree
    );
        logic [IDX_W-1:0] v;
        v = '0;
        for (int lvl = 0; lvl < IDX_W; lvl++) begin
            for (int pos = 0; pos < (1 << lvl); pos++) begin
                if ((int'(v) >> (IDX_W - lvl)) == pos)
                    v[IDX_W - 1 - lvl] = tree[(1 << lvl) - 1 + pos];
            end
        end
        return v;
    endfunction

    assign look_tag       = lookup_pc[PC_W-1:2];
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Reset gates ready combinationally so it drops the moment rst_n falls.
    assign upd_ready = rst_n & (state_q == ST_IDLE) & ~flush;

    // At most one entry can match, so the last-assignment-wins loop is safe.
    always_comb begin
        lookup_hit    = 1'b0;
        hit_way       = '0;
        lookup_target = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == look_tag)) begin
                lookup_hit    = 1'b1;
                hit_way       = IDX_W'(i);
                lookup_target = tgt_q[i];
            end
        end
    end

    // Descending scan so the lowest-index invalid way is the one kept.
    always_comb begin
        match_found = 1'b0;
        match_way   = '0;
        inv_found   = 1'b0;
        inv_way     = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == upd_tag_q)) begin
                match_found = 1'b1;
                match_way   = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                inv_found = 1'b1;
                inv_way   = IDX_W'(i);
            end
        end
        if (match_found)
            alloc_way = match_way;
        else if (inv_found)
            alloc_way = inv_way;
        else
            alloc_way = plru_victim(plru_q);
    end

    // Lookup touch first, allocation touch second: allocation owns shared nodes.
    always_comb begin
        plru_next = plru_q;
        if (lookup_en && lookup_hit)
            plru_next = plru_touch(plru_next, hit_way);
        if (state_q == ST_ALLOC)
            plru_next = plru_touch(plru_next, alloc_way);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            plru_q  <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            plru_q  <= '0;
        end else begin
            plru_q <= plru_next;
            case (state_q)
                ST_IDLE: begin
                    if (upd_valid)
                        state_q <= ST_ALLOC;
                end
                ST_ALLOC: begin
                    valid_q[alloc_way] <= 1'b1;
                    state_q            <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Payload storage carries no reset; valid_q alone qualifies it.
    always_ff @(posedge clk) begin
        if ((state_q == ST_IDLE) && upd_valid && !flush) begin
            upd_tag_q <= upd_pc[PC_W-1:2];
            upd_tgt_q <= upd_target;
        end
        if ((state_q == ST_ALLOC) && !flush) begin
            tag_q[alloc_way] <= upd_tag_q;
            tgt_q[alloc_way] <= upd_tgt_q;
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// -----------------------------------------------------------------------------
// tb_btb_assoc : directed scoreboard bench for btb_assoc (ENTRIES=4, PC_W=32)
//
// Stimulus pushes hand-computed expectations into a queue; the monitor pops
// and compares them at each falling edge, or immediately on async_ev when a
// check must happen without a clock edge. PLRU bits are {b2,b1,b0}.
// -----------------------------------------------------------------------------
module tb_btb_assoc;

    localparam int K_HIT   = 0;
    localparam int K_TGT   = 1;
    localparam int K_RDY   = 2;
    localparam int K_PLRU  = 3;
    localparam int K_VALID = 4;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] lookup_pc;
    logic        lookup_en;
    logic        lookup_hit;
    logic [31:0] lookup_target;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        flush;

    sb_t         sb_q [$];
    sb_t         mon_e;
    logic [31:0] mon_act;
    int          tests  = 0;
    int          failed = 0;
    event        async_ev;

    btb_assoc #(.ENTRIES(4), .PC_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_pc     (lookup_pc),
        .lookup_en     (lookup_en),
        .lookup_hit    (lookup_hit),
        .lookup_target (lookup_target),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .flush         (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always begin
        @(negedge clk or async_ev);
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            case (mon_e.kind)
                K_HIT:   mon_act = {31'b0, lookup_hit};
                K_TGT:   mon_act = lookup_target;
                K_RDY:   mon_act = {31'b0, upd_ready};
                K_PLRU:  mon_act = 32'(dut.plru_q);
                default: mon_act = 32'(dut.valid_q);
            endcase
            tests++;
            if (mon_act !== mon_e.exp) begin
                failed++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input int kind, input logic [31:0] val);
        sb_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = val;
        sb_q.push_back(e);
    endtask

    task automatic look(input logic [31:0] pc, input logic hit, input logic [31:0] tgt,
                        input string name);
        lookup_pc = pc;
        expect_val({name, "_hit"}, K_HIT, {31'b0, hit});
        expect_val({name, "_tgt"}, K_TGT, tgt);
        tick();
    endtask

    // Returns one time unit into the ALLOC cycle.
    task automatic issue_update(input logic [31:0] pc, input logic [31:0] tgt, input string name);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = tgt;
        expect_val({name, "_rdy_idle"}, K_RDY, 32'd1);
        tick();
        upd_valid = 1'b0;
        expect_val({name, "_rdy_alloc"}, K_RDY, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        lookup_pc  = 32'h100;
        lookup_en  = 1'b0;
        upd_valid  = 1'b0;
        upd_pc     = 32'h0;
        upd_target = 32'h0;
        flush      = 1'b0;

        // held in reset
        tick();
        expect_val("rst_hit",   K_HIT,   32'd0);
        expect_val("rst_tgt",   K_TGT,   32'd0);
        expect_val("rst_rdy",   K_RDY,   32'd0);
        expect_val("rst_plru",  K_PLRU,  32'd0);
        expect_val("rst_valid", K_VALID, 32'd0);
        tick();
        rst_n = 1'b1;
        expect_val("post_rst_hit",  K_HIT,  32'd0);
        expect_val("post_rst_tgt",  K_TGT,  32'd0);
        expect_val("post_rst_rdy",  K_RDY,  32'd1);
        expect_val("post_rst_plru", K_PLRU, 32'd0);

        // fill ways 0..3; A becomes visible two edges after acceptance
        expect_val("a_pre_hit", K_HIT, 32'd0);
        issue_update(32'h100, 32'h200, "a");
        expect_val("a_nofwd_hit", K_HIT, 32'd0);
        tick();
        expect_val("a_vis_hit", K_HIT, 32'd1);
        expect_val("a_vis_tgt", K_TGT, 32'h200);
        issue_update(32'h104, 32'h204, "b");
        tick();
        issue_update(32'h108, 32'h208, "c");
        tick();
        issue_update(32'h10C, 32'h20C, "d");
        tick();
        expect_val("fill_plru",  K_PLRU,  32'b000);
        expect_val("fill_valid", K_VALID, 32'hF);
        look(32'h108, 1'b1, 32'h208, "fill_c");

        // touch way 0, then E replaces the victim way 2
        lookup_pc = 32'h100;
        lookup_en = 1'b1;
        expect_val("touch0_hit", K_HIT, 32'd1);
        expect_val("touch0_tgt", K_TGT, 32'h200);
        tick();
        lookup_en = 1'b0;
        expect_val("touch0_plru", K_PLRU, 32'b011);
        issue_update(32'h110, 32'h210, "e");
        tick();
        expect_val("e_plru", K_PLRU, 32'b110);
        look(32'h108, 1'b0, 32'h0,   "e_evicted_c");
        look(32'h110, 1'b1, 32'h210, "e_new");
        look(32'h100, 1'b1, 32'h200, "e_keep_a");

        // steer the victim to way 3, then overwrite 0x104 in place while a
        // same-edge lookup touch of way 2 competes for the root node
        lookup_pc = 32'h104;
        lookup_en = 1'b1;
        expect_val("touch1_hit", K_HIT, 32'd1);
        tick();
        lookup_en = 1'b0;
        expect_val("touch1_plru", K_PLRU, 32'b101);
        issue_update(32'h104, 32'h300, "b2");
        lookup_pc = 32'h110;
        lookup_en = 1'b1;
        expect_val("b2_alloc_look_hit", K_HIT, 32'd1);
        expect_val("b2_alloc_look_tgt", K_TGT, 32'h210);
        tick();
        lookup_en = 1'b0;
        expect_val("b2_plru_order", K_PLRU,  32'b101);
        expect_val("b2_valid",      K_VALID, 32'hF);
        look(32'h104, 1'b1, 32'h300, "b2_new_tgt");
        look(32'h10C, 1'b1, 32'h20C, "b2_keep_d");

        // flush during ALLOC aborts the write
        issue_update(32'h114, 32'h214, "f");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_val("flush_plru",  K_PLRU,  32'd0);
        expect_val("flush_valid", K_VALID, 32'd0);
        expect_val("flush_rdy",   K_RDY,   32'd1);
        look(32'h100, 1'b0, 32'h0, "flush_a");
        look(32'h110, 1'b0, 32'h0, "flush_e");
        look(32'h114, 1'b0, 32'h0, "flush_f");
        issue_update(32'h118, 32'h218, "g");
        tick();
        expect_val("g_valid", K_VALID, 32'h1);
        expect_val("g_plru",  K_PLRU,  32'b011);
        look(32'h118, 1'b1, 32'h218, "g_way0");

        // asynchronous reset in the middle of ALLOC
        issue_update(32'h11C, 32'h21C, "h");
        lookup_pc = 32'h118;
        #1;
        expect_val("h_pre_rst_hit", K_HIT, 32'd1);
        -> async_ev;
        #1;
        rst_n = 1'b0;
        #1;
        expect_val("async_rst_hit",   K_HIT,   32'd0);
        expect_val("async_rst_tgt",   K_TGT,   32'd0);
        expect_val("async_rst_rdy",   K_RDY,   32'd0);
        expect_val("async_rst_valid", K_VALID, 32'd0);
        expect_val("async_rst_plru",  K_PLRU,  32'd0);
        -> async_ev;
        tick();
        rst_n = 1'b1;
        expect_val("rel_rdy",   K_RDY,   32'd1);
        expect_val("rel_valid", K_VALID, 32'd0);
        look(32'h11C, 1'b0, 32'h0, "rel_discard_h");
        look(32'h100, 1'b0, 32'h0, "rel_a");
        tick();
        expect_val("rel_valid_later", K_VALID, 32'd0);
        tick();

        tests++;
        if (sb_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
